pose_accumulator: RTL and testbench
===================================

// Module: pose_accumulator
// PURPOSE
//  Datapath end of the object-motion controller: consumes per-axis Enable/add_sub step commands, holds
//  object pose (X,Y,Z position; R1,R2,R3 rotation) and offers pose snapshots to the renderer/plotter.
//  Sits between the button-decoding control FSM and the 3D projection/plot pipeline.
//  Snapshot transfer uses a valid/ready handshake.
// PARAMETERS
//  COORD_W    8   width of X/Y/Z (unsigned)
//  ANG_W      6   width of R1/R2/R3 (unsigned, 2^ANG_W steps per turn)
//  STEP       1   magnitude added/subtracted per Enable cycle, all axes
//  COORD_INIT 0   reset value of X/Y/Z
// PORTS
//  clock       in   1   clock
//  resetn      in   1   reset, asynchronous, active-low
//  EnableX/Y/Z       in 1 step enable per position axis, one step per cycle high
//  add_sub_X/Y/Z     in 1 1 = add STEP, 0 = subtract STEP (sampled only when matching Enable high)
//  EnableR1/R2/R3    in 1 step enable per rotation axis
//  add_sub_R1/R2/R3  in 1 direction for rotation axis, same encoding
//  plot_dot    in   1   force a snapshot offer even if pose unchanged
//  plot_ready  in   1   renderer accepts snapshot
//  pos_x/y/z   out  COORD_W  live position
//  rot_1/2/3   out  ANG_W    live rotation
//  plot_valid  out  1   snapshot offered
//  plot_pose   out  3*COORD_W+3*ANG_W  snapshot {x,y,z,r1,r2,r3}, x in MSBs
// BEHAVIOUR
//  Reset (async, resetn=0): pos_* = COORD_INIT, rot_* = 0, plot_valid = 0, plot_pose = 0, pending = 0, state IDLE.
//  Axis update, per cycle, independent per axis, visible on live outputs 1 cycle after Enable sampled high.
//  Rotation: modulo 2^ANG_W wrap (0 - STEP -> 2^ANG_W-STEP; max + STEP wraps).
//  Position: saturate at 0 and 2^COORD_W-1 (default build, see CONFIGURATION); no change, no error flag.
//  pending flag: set in any cycle where any Enable is high or plot_dot high; cleared when snapshot captured.
//  FSM IDLE/OFFER:
//   IDLE: if pending -> capture live pose (post-update value of this cycle's edge) into plot_pose,
//         clear pending, plot_valid=1, go OFFER. Latency: Enable at edge n -> plot_valid at edge n+2.
//   OFFER: plot_pose and plot_valid held stable while plot_ready=0 (no change even if axes move).
//          plot_valid & plot_ready -> transfer; if pending (incl. set this same cycle) recapture, stay OFFER
//          with plot_valid=1; else plot_valid=0, go IDLE.
//  Simultaneous Enable + accept: axis updates, pending set, next snapshot carries the new value; never lost.
//  Multiple updates during OFFER coalesce into one follow-up snapshot (latest pose only).
//  plot_ready while IDLE ignored. Reset mid-OFFER drops the snapshot; plot_valid falls asynchronously.
//  Illegal FSM encoding -> IDLE.
// CONFIGURATION
//  COORD_WRAP_EN defined: X/Y/Z wrap modulo 2^COORD_W like rotations (toroidal scene).
//  COORD_WRAP_EN undefined: X/Y/Z saturate as above. Rotations always wrap.
// STRUCTURE
//  Package pose_pkg: COORD_W/ANG_W defaults, POSE_W = 3*COORD_W+3*ANG_W, pose struct typedef
//   {x,y,z,r1,r2,r3}, FSM state enum {IDLE, OFFER}.
//  Sub-module axis_step_counter (WIDTH, STEP, INIT, WRAP): enable/add_sub in, value out; instantiated
//   3x with WRAP = COORD_WRAP_EN-selected, 3x with WRAP=1. Top holds pending flag, FSM, snapshot reg.
// TESTING
//  Reset then EnableX=1,add_sub_X=1 for 3 cycles -> pos_x 0,1,2,3; plot_valid=1 with x=1, held until ready.
//  rot_1=0, EnableR1=1,add_sub_R1=0 one cycle -> rot_1=63 (ANG_W=6); then add 1 -> 0.
//  pos_y=255, add 1 -> stays 255; rebuild with COORD_WRAP_EN -> 0. pos_y=0 subtract -> 0 / 255.
//  plot_ready=0 for 10 cycles while EnableZ toggles -> plot_pose constant; on ready, exactly one follow-up
//   snapshot with latest z, then plot_valid=0.
//  Enable and plot_ready high same cycle in OFFER -> plot_valid stays 1, new plot_pose next cycle.
//  plot_dot pulse with no Enable -> one snapshot of unchanged pose; resetn low during OFFER -> plot_valid=0 immediately.

Source files
------------

// File: rtl/pose_pkg.sv
// rtl/pose_pkg.sv - shared widths, pose record and handshake FSM states for pose_accumulator
package pose_pkg;

  localparam int COORD_W_DEF = 8;
  localparam int ANG_W_DEF   = 6;
  localparam int POSE_W      = 3 * COORD_W_DEF + 3 * ANG_W_DEF;

  // x sits in the MSBs so the packed struct matches the plot_pose bus layout
  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [COORD_W_DEF-1:0] z;
    logic [ANG_W_DEF-1:0]   r1;
    logic [ANG_W_DEF-1:0]   r2;
    logic [ANG_W_DEF-1:0]   r3;
  } pose_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/axis_step_counter.sv
// rtl/axis_step_counter.sv - one pose axis: steps by STEP per enabled cycle, wrapping or saturating
module axis_step_counter #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int INIT  = 0,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             add_sub,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH:0]   sum, diff;

  // The extra MSB of sum/diff is the carry/borrow that decides saturation
  always_comb begin
    sum     = {1'b0, value_q} + (WIDTH+1)'(STEP);
    diff    = {1'b0, value_q} - (WIDTH+1)'(STEP);
    value_d = value_q;
    if (enable) begin
      if (add_sub) begin
        value_d = (sum[WIDTH] && !WRAP) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      end else begin
        value_d = (diff[WIDTH] && !WRAP) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) value_q <= WIDTH'(INIT);
    else         value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/pose_accumulator.sv
// rtl/pose_accumulator.sv - pose registers plus valid/ready snapshot offer; COORD_WRAP_EN makes X/Y/Z wrap
module pose_accumulator
  import pose_pkg::*;
#(
  parameter int COORD_W    = COORD_W_DEF,
  parameter int ANG_W      = ANG_W_DEF,
  parameter int STEP       = 1,
  parameter int COORD_INIT = 0
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           EnableX,
  input  logic                           EnableY,
  input  logic                           EnableZ,
  input  logic                           add_sub_X,
  input  logic                           add_sub_Y,
  input  logic                           add_sub_Z,
  input  logic                           EnableR1,
  input  logic                           EnableR2,
  input  logic                           EnableR3,
  input  logic                           add_sub_R1,
  input  logic                           add_sub_R2,
  input  logic                           add_sub_R3,
  input  logic                           plot_dot,
  input  logic                           plot_ready,
  output logic [COORD_W-1:0]             pos_x,
  output logic [COORD_W-1:0]             pos_y,
  output logic [COORD_W-1:0]             pos_z,
  output logic [ANG_W-1:0]               rot_1,
  output logic [ANG_W-1:0]               rot_2,
  output logic [ANG_W-1:0]               rot_3,
  output logic                           plot_valid,
  output logic [3*COORD_W+3*ANG_W-1:0]   plot_pose
);

  localparam int PW = 3 * COORD_W + 3 * ANG_W;
`ifdef COORD_WRAP_EN
  localparam bit COORD_WRAP = 1'b1;
`else
  localparam bit COORD_WRAP = 1'b0;
`endif

  axis_step_counter #(.WIDTH(COORD_W), .STEP(STEP), .INIT(COORD_INIT), .WRAP(COORD_WRAP)) u_x (
    .clock(clock), .resetn(resetn), .enable(EnableX), .add_sub(add_sub_X), .value(pos_x));
  axis_step_counter #(.WIDTH(COORD_W), .STEP(STEP), .INIT(COORD_INIT), .WRAP(COORD_WRAP)) u_y (
    .clock(clock), .resetn(resetn), .enable(EnableY), .add_sub(add_sub_Y), .value(pos_y));
  axis_step_counter #(.WIDTH(COORD_W), .STEP(STEP), .INIT(COORD_INIT), .WRAP(COORD_WRAP)) u_z (
    .clock(clock), .resetn(resetn), .enable(EnableZ), .add_sub(add_sub_Z), .value(pos_z));
  axis_step_counter #(.WIDTH(ANG_W), .STEP(STEP), .INIT(0), .WRAP(1'b1)) u_r1 (
    .clock(clock), .resetn(resetn), .enable(EnableR1), .add_sub(add_sub_R1), .value(rot_1));
  axis_step_counter #(.WIDTH(ANG_W), .STEP(STEP), .INIT(0), .WRAP(1'b1)) u_r2 (
    .clock(clock), .resetn(resetn), .enable(EnableR2), .add_sub(add_sub_R2), .value(rot_2));
  axis_step_counter #(.WIDTH(ANG_W), .STEP(STEP), .INIT(0), .WRAP(1'b1)) u_r3 (
    .clock(clock), .resetn(resetn), .enable(EnableR3), .add_sub(add_sub_R3), .value(rot_3));

  state_e          state_q, state_d;
  logic            pending_q, pending_d;
  logic [PW-1:0]   pose_q, pose_d;
  logic            any_event;
  logic            capture;
  logic [PW-1:0]   live_pose;

  assign any_event = EnableX | EnableY | EnableZ | EnableR1 | EnableR2 | EnableR3 | plot_dot;
  assign live_pose = {pos_x, pos_y, pos_z, rot_1, rot_2, rot_3};

  // A capture takes the registered pose, so an event in the capture cycle
  // itself is not in that snapshot and must leave pending set.
  always_comb begin
    state_d   = state_q;
    pose_d    = pose_q;
    pending_d = pending_q | any_event;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          capture = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (plot_ready) begin
          if (pending_q || any_event) capture = 1'b1;
          else                        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      pose_d    = live_pose;
      pending_d = any_event;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      pose_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      pose_q    <= pose_d;
    end
  end

  assign plot_valid = (state_q == OFFER);
  assign plot_pose  = pose_q;

endmodule

// File: tb/tb_pose_accumulator.sv
// tb/tb_pose_accumulator.sv - self-checking bench for pose_accumulator (either COORD_WRAP_EN build)
module tb_pose_accumulator;
  import pose_pkg::*;

  logic clock = 1'b0;
  logic resetn;
  logic [5:0] en;   // 0..5 = X,Y,Z,R1,R2,R3
  logic [5:0] dir;
  logic plot_dot, plot_ready;
  logic [7:0] pos_x, pos_y, pos_z;
  logic [5:0] rot_1, rot_2, rot_3;
  logic plot_valid;
  logic [POSE_W-1:0] plot_pose;
  pose_t pp;

  assign pp = plot_pose;

  pose_accumulator dut (
    .clock(clock), .resetn(resetn),
    .EnableX(en[0]), .EnableY(en[1]), .EnableZ(en[2]),
    .add_sub_X(dir[0]), .add_sub_Y(dir[1]), .add_sub_Z(dir[2]),
    .EnableR1(en[3]), .EnableR2(en[4]), .EnableR3(en[5]),
    .add_sub_R1(dir[3]), .add_sub_R2(dir[4]), .add_sub_R3(dir[5]),
    .plot_dot(plot_dot), .plot_ready(plot_ready),
    .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
    .rot_1(rot_1), .rot_2(rot_2), .rot_3(rot_3),
    .plot_valid(plot_valid), .plot_pose(plot_pose));

  always #5 clock = ~clock;

`ifdef COORD_WRAP_EN
  localparam bit CW = 1'b1;
`else
  localparam bit CW = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int m [6];

  // Reference: integer arithmetic on the ideal pose, one step per enabled cycle
  function automatic int upd(int v, bit e, bit add, int w, bit wrap);
    int n, lim;
    if (!e) return v;
    lim = 1 << w;
    n = add ? v + 1 : v - 1;
    if (wrap) return (n + lim) % lim;
    if (n < 0) return 0;
    if (n > lim - 1) return lim - 1;
    return n;
  endfunction

  function automatic logic [POSE_W-1:0] model_pose();
    return {8'(m[0]), 8'(m[1]), 8'(m[2]), 6'(m[3]), 6'(m[4]), 6'(m[5])};
  endfunction

  function automatic logic [POSE_W-1:0] live();
    return {pos_x, pos_y, pos_z, rot_1, rot_2, rot_3};
  endfunction

  function automatic int axis_val(int i);
    case (i)
      0: return int'(pos_x);
      1: return int'(pos_y);
      2: return int'(pos_z);
      3: return int'(rot_1);
      4: return int'(rot_2);
      default: return int'(rot_3);
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    for (int i = 0; i < 6; i++) m[i] = upd(m[i], en[i], dir[i], (i < 3) ? 8 : 6, (i < 3) ? CW : 1'b1);
    #1;
  endtask

  task automatic do_reset();
    en = '0; dir = '0; plot_dot = 1'b0;
    resetn = 1'b0;
    for (int i = 0; i < 6; i++) m[i] = 0;
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  task automatic dot_to_offer();
    plot_ready = 1'b0; plot_dot = 1'b1;
    tick();
    plot_dot = 1'b0;
    tick();
  endtask

  typedef struct {
    int axis;
    bit add;
    int n;
    int exp_sat;
    int exp_wrap;
  } vec_t;
  vec_t tbl [11];

  logic [POSE_W-1:0] hist [$];
  logic [POSE_W-1:0] held, last_acc, saved;
  bit prev_hold, found;

  initial begin
    tbl[0]  = '{0, 1'b1, 3,   3,   3};
    tbl[1]  = '{0, 1'b0, 4,   0,   255};
    tbl[2]  = '{1, 1'b0, 1,   0,   255};
    tbl[3]  = '{1, 1'b1, 255, 255, 254};
    tbl[4]  = '{1, 1'b1, 1,   255, 255};
    tbl[5]  = '{3, 1'b0, 1,   63,  63};
    tbl[6]  = '{3, 1'b1, 1,   0,   0};
    tbl[7]  = '{4, 1'b1, 64,  0,   0};
    tbl[8]  = '{5, 1'b1, 70,  6,   6};
    tbl[9]  = '{2, 1'b1, 10,  10,  10};
    tbl[10] = '{2, 1'b0, 3,   7,   7};

    plot_ready = 1'b0;
    do_reset();
    check("reset_pose", live(), '0);
    check("reset_valid", plot_valid, 0);
    check("reset_plot_pose", plot_pose, '0);

    // X steps up three times; first snapshot carries x=1 and holds without ready
    en[0] = 1'b1; dir[0] = 1'b1;
    tick();
    check("x_step1", pos_x, 1);
    check("x_step1_valid", plot_valid, 0);
    tick();
    check("x_step2", pos_x, 2);
    check("x_first_valid", plot_valid, 1);
    check("x_first_snap", pp.x, 1);
    tick();
    check("x_step3", pos_x, 3);
    en = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("x_snap_held", pp.x, 1);
      check("x_valid_held", plot_valid, 1);
    end
    plot_ready = 1'b1;
    tick();
    check("x_followup_valid", plot_valid, 1);
    check("x_followup_snap", pp.x, 3);
    tick();
    check("x_drained", plot_valid, 0);

    // plot_dot snapshot, then Z moves during a 10-cycle stall
    dot_to_offer();
    check("dot_valid", plot_valid, 1);
    check("dot_snap", plot_pose, model_pose());
    saved = plot_pose;
    for (int i = 0; i < 10; i++) begin
      en[2] = (i % 2 == 0); dir[2] = 1'b1;
      tick();
      check("stall_pose_stable", plot_pose, saved);
      check("stall_valid", plot_valid, 1);
    end
    en = '0; plot_ready = 1'b1;
    tick();
    check("stall_followup_valid", plot_valid, 1);
    check("stall_followup_latest", plot_pose, model_pose());
    tick();
    check("stall_single_followup", plot_valid, 0);

    // Enable in the same cycle as acceptance
    dot_to_offer();
    en[0] = 1'b1; dir[0] = 1'b1; plot_ready = 1'b1;
    tick();
    en = '0;
    check("accept_en_valid", plot_valid, 1);
    tick();
    check("accept_en_valid2", plot_valid, 1);
    check("accept_en_new_pose", plot_pose, model_pose());
    tick();
    check("accept_en_drained", plot_valid, 0);

    // Reset in OFFER drops valid without waiting for an edge
    dot_to_offer();
    check("pre_reset_valid", plot_valid, 1);
    resetn = 1'b0;
    #1;
    check("async_reset_valid", plot_valid, 0);
    check("async_reset_pose", plot_pose, '0);
    do_reset();

    // Table: axis arithmetic boundaries
    plot_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      en[tbl[k].axis] = 1'b1; dir[tbl[k].axis] = tbl[k].add;
      for (int c = 0; c < tbl[k].n; c++) tick();
      en = '0;
      check($sformatf("tbl%0d_axis%0d", k, tbl[k].axis), axis_val(tbl[k].axis),
            CW ? tbl[k].exp_wrap : tbl[k].exp_sat);
    end

    // Randomized run against the arithmetic model and handshake properties
    do_reset();
    plot_ready = 1'b0;
    prev_hold = 1'b0;
    hist.push_back(model_pose());
    last_acc = '0;
    for (int c = 0; c < 500; c++) begin
      tick();
      check("rand_live", live(), model_pose());
      if (prev_hold) begin
        check("rand_hold_valid", plot_valid, 1);
        check("rand_hold_pose", plot_pose, held);
      end
      if (plot_valid) begin
        found = 1'b0;
        foreach (hist[h]) if (hist[h] == plot_pose) found = 1'b1;
        check("rand_snap_in_history", found, 1);
      end
      hist.push_back(model_pose());
      for (int i = 0; i < 6; i++) begin
        en[i]  = ($urandom_range(3) == 0);
        dir[i] = $urandom_range(1);
      end
      plot_dot   = ($urandom_range(15) == 0);
      plot_ready = $urandom_range(1);
      prev_hold  = plot_valid && !plot_ready;
      held       = plot_pose;
      if (plot_valid && plot_ready) last_acc = plot_pose;
    end
    en = '0; plot_dot = 1'b0; plot_ready = 1'b1;
    for (int c = 0; c < 8 && plot_valid; c++) begin
      last_acc = plot_pose;
      tick();
    end
    check("drain_timeout", plot_valid, 0);
    check("final_snapshot_latest", last_acc, model_pose());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
